// File: rtl/edl_sync_bridge.sv
// edl_sync_bridge: clocked environment-side partner for an EDL token controller.
// Drives the controller's left channel as a 4-phase bundled-data initiator,
// mirrors the left error channel, and drains the right channel as a 4-phase
// responder. Both directions are exposed as synchronous valid/ready streams.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-low reset
//   in_data/in_valid/in_ready    clocked TX stream into the bridge
//   Lreq/Ldata/Lack              4-phase left channel (Lack asynchronous)
//   LEreq/LEack                  left error channel (LEreq asynchronous)
//   Rreq/Rdata/Rack              4-phase right channel (Rreq asynchronous)
//   out_data/out_valid/out_ready clocked RX stream out of the bridge
//   tx_count/rx_count            completed handshakes, wrap at 16 bits
//   tx_timeout                   sticky: a TX phase stalled TIMEOUT cycles
module edl_sync_bridge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             Lreq,
  output logic [WIDTH-1:0] Ldata,
  input  logic             Lack,
  input  logic             LEreq,
  output logic             LEack,
  input  logic             Rreq,
  input  logic [WIDTH-1:0] Rdata,
  output logic             Rack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      tx_count,
  output logic [15:0]      rx_count,
  output logic             tx_timeout
);

  typedef enum logic [1:0] {T_IDLE, T_SETUP, T_REQ, T_REL} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_HOLD} rx_state_e;

  // Synchronizer chains; the MSB is the synchronized value.
  logic [SYNC_STAGES-1:0] lack_sync_q, lack_sync_d;
  logic [SYNC_STAGES-1:0] lereq_sync_q, lereq_sync_d;
  logic [SYNC_STAGES-1:0] rreq_sync_q, rreq_sync_d;
  logic s_lack, s_lereq, s_rreq;

  tx_state_e        tx_state_q, tx_state_d;
  logic [WIDTH-1:0] ldata_q, ldata_d;
  logic             lreq_q, lreq_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      tx_count_q, tx_count_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic             tx_timeout_q, tx_timeout_d;
  logic             le_ack_q, le_ack_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic             rack_q, rack_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      rx_count_q, rx_count_d;

  logic             tx_waiting;

  always_comb begin
    lack_sync_d  = {lack_sync_q[SYNC_STAGES-2:0], Lack};
    lereq_sync_d = {lereq_sync_q[SYNC_STAGES-2:0], LEreq};
    rreq_sync_d  = {rreq_sync_q[SYNC_STAGES-2:0], Rreq};
  end

  assign s_lack  = lack_sync_q[SYNC_STAGES-1];
  assign s_lereq = lereq_sync_q[SYNC_STAGES-1];
  assign s_rreq  = rreq_sync_q[SYNC_STAGES-1];

  // LE responder: plain registered mirror of the synchronized request.
  assign le_ack_d = s_lereq;

  // TX initiator
  always_comb begin
    tx_state_d = tx_state_q;
    ldata_d    = ldata_q;
    lreq_d     = lreq_q;
    tx_count_d = tx_count_q;
    unique case (tx_state_q)
      T_IDLE: begin
        if (in_valid && in_ready_q) begin
          ldata_d    = in_data;
          tx_state_d = T_SETUP;
        end
      end
      T_SETUP: begin
        lreq_d     = 1'b1;
        tx_state_d = T_REQ;
      end
      T_REQ: begin
        if (s_lack) begin
          lreq_d     = 1'b0;
          tx_state_d = T_REL;
        end
      end
      T_REL: begin
        if (!s_lack) begin
          tx_count_d = tx_count_q + 16'd1;
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase

    // in_ready is registered, so it is computed from the next state and
    // the next LEack value to stay aligned with them.
    in_ready_d = (tx_state_d == T_IDLE) && !s_lack && !le_ack_d;
  end

  // Stall counter: runs while waiting on the partner, restarts on every
  // state change and saturates at TIMEOUT.
  always_comb begin
    tx_waiting   = (tx_state_q == T_REQ) || (tx_state_q == T_REL);
    to_cnt_d     = to_cnt_q;
    tx_timeout_d = tx_timeout_q;
    if (tx_state_d != tx_state_q) begin
      to_cnt_d = '0;
    end else if (tx_waiting && (to_cnt_q != 16'(TIMEOUT))) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
    if (tx_waiting && (to_cnt_d == 16'(TIMEOUT))) begin
      tx_timeout_d = 1'b1;
    end
  end

  // RX responder
  always_comb begin
    rx_state_d  = rx_state_q;
    rack_d      = rack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rx_count_d  = rx_count_q;

    // Consumption is independent of the handshake state.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (rx_state_q)
      R_IDLE: begin
        // Capture only into an empty output register; this is the backpressure.
        if (!out_valid_q && s_rreq) begin
          out_data_d  = Rdata;
          out_valid_d = 1'b1;
          rack_d      = 1'b1;
          rx_state_d  = R_ACK;
        end
      end
      R_ACK: begin
        if (!s_rreq) begin
          rack_d     = 1'b0;
          rx_count_d = rx_count_q + 16'd1;
          rx_state_d = R_HOLD;
        end
      end
      R_HOLD: begin
        if (!out_valid_q) begin
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lack_sync_q  <= '0;
      lereq_sync_q <= '0;
      rreq_sync_q  <= '0;
      tx_state_q   <= T_IDLE;
      ldata_q      <= '0;
      lreq_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      tx_count_q   <= '0;
      to_cnt_q     <= '0;
      tx_timeout_q <= 1'b0;
      le_ack_q     <= 1'b0;
      rx_state_q   <= R_IDLE;
      rack_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      rx_count_q   <= '0;
    end else begin
      lack_sync_q  <= lack_sync_d;
      lereq_sync_q <= lereq_sync_d;
      rreq_sync_q  <= rreq_sync_d;
      tx_state_q   <= tx_state_d;
      ldata_q      <= ldata_d;
      lreq_q       <= lreq_d;
      in_ready_q   <= in_ready_d;
      tx_count_q   <= tx_count_d;
      to_cnt_q     <= to_cnt_d;
      tx_timeout_q <= tx_timeout_d;
      le_ack_q     <= le_ack_d;
      rx_state_q   <= rx_state_d;
      rack_q       <= rack_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      rx_count_q   <= rx_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign Lreq       = lreq_q;
  assign Ldata      = ldata_q;
  assign LEack      = le_ack_q;
  assign Rack       = rack_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign tx_count   = tx_count_q;
  assign rx_count   = rx_count_q;
  assign tx_timeout = tx_timeout_q;

endmodule

// File: tb/tb_edl_sync_bridge.sv
// Self-checking bench for edl_sync_bridge: directed reset/TX/RX/LE/timeout
// steps plus a randomized mixed-traffic phase scored against word queues.
module tb_edl_sync_bridge;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int TO = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          Lreq;
  logic [W-1:0]  Ldata;
  logic          Lack;
  logic          LEreq;
  logic          LEack;
  logic          Rreq;
  logic [W-1:0]  Rdata;
  logic          Rack;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   tx_count;
  logic [15:0]   rx_count;
  logic          tx_timeout;

  // Left partner: either an instant echo of Lreq or a manually driven level.
  logic lack_auto   = 1'b0;
  logic lack_manual = 1'b1;
  logic lack_echo   = 1'b0;
  assign Lack = lack_auto ? lack_echo : lack_manual;

  always @(Lreq) begin
    #1;
    lack_echo = Lreq;
  end

  always #5 clk = ~clk;

  edl_sync_bridge #(
    .WIDTH(W),
    .SYNC_STAGES(S),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Lreq(Lreq),
    .Ldata(Ldata),
    .Lack(Lack),
    .LEreq(LEreq),
    .LEack(LEack),
    .Rreq(Rreq),
    .Rdata(Rdata),
    .Rack(Rack),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .tx_count(tx_count),
    .rx_count(rx_count),
    .tx_timeout(tx_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_rack(input logic v, input string tag);
    for (int i = 0; i < 40 && Rack !== v; i++) @(negedge clk);
    check(tag, 32'(Rack), 32'(v));
  endtask

  task automatic wait_lreq(input logic v, input string tag);
    for (int i = 0; i < 40 && Lreq !== v; i++) @(negedge clk);
    check(tag, 32'(Lreq), 32'(v));
  endtask

  task automatic wait_in_ready(input logic v, input string tag);
    for (int i = 0; i < 40 && in_ready !== v; i++) @(negedge clk);
    check(tag, 32'(in_ready), 32'(v));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] tx_exp_cnt;
    logic [15:0] rx_exp_cnt;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_exp[$];
    int rise_k, high, ready_k, req_k, to_k, le_k;
    int tx_left, rx_left, rphase;
    logic lreq_prev, done;

    tx_exp_cnt = '0;
    rx_exp_cnt = '0;

    // Reset with every async input asserted.
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    Rreq = 1'b1; Rdata = 8'h77; LEreq = 1'b1; lack_manual = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lreq", 32'(Lreq), 0);
    check("rst_rack", 32'(Rack), 0);
    check("rst_leack", 32'(LEack), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_tx_count", 32'(tx_count), 0);
    check("rst_rx_count", 32'(rx_count), 0);
    check("rst_timeout", 32'(tx_timeout), 0);
    check("rst_ldata", 32'(Ldata), 0);
    check("rst_out_data", 32'(out_data), 0);
    rst = 1'b1; lack_manual = 1'b0; Rreq = 1'b0; LEreq = 1'b0;
    repeat (S + 1) @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Single TX word against an instant-ack partner.
    lack_auto = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("tx_setup_ldata", 32'(Ldata), 32'hA5);
    check("tx_setup_lreq", 32'(Lreq), 0);
    check("tx_setup_in_ready", 32'(in_ready), 0);
    tx_exp_cnt = tx_exp_cnt + 16'd1;
    rise_k = -1; high = 0; ready_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (Lreq) begin
        high++;
        if (rise_k < 0) rise_k = k;
        check("tx_ldata_held", 32'(Ldata), 32'hA5);
      end
      if (in_ready) begin
        ready_k = k;
        break;
      end
    end
    check("tx_lreq_rise_cycle", 32'(rise_k), 1);
    check("tx_lreq_high_cycles", 32'(high), 32'(S + 1));
    check("tx_in_ready_return", 32'(ready_k), 32'(2 * S + 3));
    check("tx_count_1", 32'(tx_count), 32'(tx_exp_cnt));

    // RX backpressure: second word must wait until the first is consumed.
    out_ready = 1'b0;
    Rdata = 8'h3C; Rreq = 1'b1;
    rx_exp_cnt = rx_exp_cnt + 16'd1;
    wait_rack(1'b1, "rx1_rack_rise");
    check("rx1_out_data", 32'(out_data), 32'h3C);
    check("rx1_out_valid", 32'(out_valid), 1);
    Rreq = 1'b0; Rdata = 8'($urandom);
    wait_rack(1'b0, "rx1_rack_fall");
    check("rx1_count", 32'(rx_count), 32'(rx_exp_cnt));
    Rdata = 8'hC3; Rreq = 1'b1;
    rx_exp_cnt = rx_exp_cnt + 16'd1;
    repeat (10) @(negedge clk);
    check("rx2_blocked_rack", 32'(Rack), 0);
    check("rx2_blocked_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rx1_consumed", 32'(out_valid), 0);
    wait_rack(1'b1, "rx2_rack_rise");
    check("rx2_out_data", 32'(out_data), 32'hC3);
    check("rx2_out_valid", 32'(out_valid), 1);
    Rreq = 1'b0;
    wait_rack(1'b0, "rx2_rack_fall");
    check("rx2_count", 32'(rx_count), 32'(rx_exp_cnt));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rx2_consumed", 32'(out_valid), 0);

    // LE mirror latency and its hold on in_ready.
    LEreq = 1'b1;
    le_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (LEack) begin le_k = k; break; end
    end
    check("le_rise_latency", 32'(le_k), 32'(S + 1));
    check("le_blocks_in_ready", 32'(in_ready), 0);
    LEreq = 1'b0;
    le_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!LEack) begin le_k = k; break; end
    end
    check("le_fall_latency", 32'(le_k), 32'(S + 1));
    check("le_release_in_ready", 32'(in_ready), 1);

    // Randomized concurrent TX / RX / LE traffic.
    tx_left = 40; rx_left = 40; rphase = 0; done = 1'b0;
    lreq_prev = Lreq;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (Lreq && !lreq_prev) begin
        check("tx_q_nonempty", 32'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) check("rand_ldata", 32'(Ldata), 32'(tx_q.pop_front()));
      end
      lreq_prev = Lreq;

      in_valid = (tx_left > 0) && ($urandom_range(0, 1) == 1);
      in_data  = 8'($urandom);
      if (in_valid && in_ready) begin
        tx_q.push_back(in_data);
        tx_left--;
        tx_exp_cnt = tx_exp_cnt + 16'd1;
      end

      if (cyc < 2000) begin
        if ($urandom_range(0, 15) == 0) LEreq = ~LEreq;
      end else begin
        LEreq = 1'b0;
      end

      case (rphase)
        0: if (rx_left > 0 && $urandom_range(0, 1) == 1) begin
             Rdata = 8'($urandom);
             Rreq = 1'b1;
             rx_exp.push_back(Rdata);
             rx_left--;
             rx_exp_cnt = rx_exp_cnt + 16'd1;
             rphase = 1;
           end
        1: if (Rack) begin
             Rreq = 1'b0;
             Rdata = 8'($urandom);
             rphase = 2;
           end
        default: if (!Rack) rphase = 0;
      endcase

      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        check("rx_exp_nonempty", 32'(rx_exp.size() != 0), 1);
        if (rx_exp.size() != 0) check("rand_out_data", 32'(out_data), 32'(rx_exp.pop_front()));
      end

      if (cyc >= 2000 && tx_left == 0 && rx_left == 0 && rphase == 0 &&
          tx_q.size() == 0 && rx_exp.size() == 0 && in_ready && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand_drained", 32'(done), 1);
    check("rand_tx_count", 32'(tx_count), 32'(tx_exp_cnt));
    check("rand_rx_count", 32'(rx_count), 32'(rx_exp_cnt));
    check("rand_no_timeout", 32'(tx_timeout), 0);

    // Timeout: partner never acknowledges.
    lack_auto = 1'b0; lack_manual = 1'b0;
    wait_in_ready(1'b1, "to_ready");
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    tx_exp_cnt = tx_exp_cnt + 16'd1;
    req_k = -1; to_k = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (Lreq && req_k < 0) req_k = k;
      if (tx_timeout) begin to_k = k; break; end
    end
    check("to_lreq_seen", 32'(req_k), 1);
    check("to_latency", 32'(to_k - req_k), 32'(TO));
    lack_manual = 1'b1;
    wait_lreq(1'b0, "to_lreq_fall");
    lack_manual = 1'b0;
    wait_in_ready(1'b1, "to_complete");
    check("to_sticky", 32'(tx_timeout), 1);
    check("to_tx_count", 32'(tx_count), 32'(tx_exp_cnt));
    rst = 1'b0;
    @(negedge clk);
    check("to_cleared_by_rst", 32'(tx_timeout), 0);
    check("rst2_tx_count", 32'(tx_count), 0);
    check("rst2_rx_count", 32'(rx_count), 0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
